// File: rtl/spi_mon_pkg.sv
// rtl/spi_mon_pkg.sv - shared types and constants for the SPI frame monitor
package spi_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;

    // Sensor setup sequence: both registers must hold these values
    localparam logic [6:0] DEF_SETUP_ADDR0 = 7'h0D;
    localparam logic [7:0] DEF_SETUP_VAL0  = 8'h02;
    localparam logic [6:0] DEF_SETUP_ADDR1 = 7'h11;
    localparam logic [7:0] DEF_SETUP_VAL1  = 8'h50;

endpackage

// File: rtl/spi_frame_monitor_sat_counter.sv
// rtl/spi_frame_monitor_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 8
) (
    input  logic         SCLK,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_monitor.sv
// rtl/spi_frame_monitor.sv - passive SPI frame decoder with register shadow and statistics
module spi_frame_monitor
    import spi_mon_pkg::*;
#(
    parameter int               ADDR_W      = 7,
    parameter int               CNT_W       = 8,
    parameter logic [ADDR_W-1:0] SETUP_ADDR0 = DEF_SETUP_ADDR0,
    parameter logic [7:0]        SETUP_VAL0  = DEF_SETUP_VAL0,
    parameter logic [ADDR_W-1:0] SETUP_ADDR1 = DEF_SETUP_ADDR1,
    parameter logic [7:0]        SETUP_VAL1  = DEF_SETUP_VAL1
) (
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              MISO,
    output logic              frm_rd,
    output logic [ADDR_W-1:0] frm_addr,
    output logic [7:0]        frm_wdata,
    output logic [7:0]        frm_rdata,
    output logic [CNT_W-1:0]  frm_seq,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  abort_cnt,
    output logic              setup_done,
    input  logic [ADDR_W-1:0] shd_addr,
    output logic [7:0]        shd_data
);

    logic                  frame_clr;
    logic [3:0]            bit_cnt;
    logic [3:0]            bit_cnt_nxt;
    state_t                state;
    state_t                state_nxt;
    logic                  complete;
    logic [FRAME_BITS-2:0] mosi_sr;
    logic [FRAME_BITS-2:0] miso_sr;
    logic [FRAME_BITS-1:0] mosi_word;
    logic [FRAME_BITS-1:0] miso_word;
    logic                  partial;
    logic                  frame_done;
    logic                  wr_inc;
    logic                  rd_inc;
    logic                  abort_inc;
    logic [7:0]            shadow [0:(1<<ADDR_W)-1];

    // Deselect wipes only the in-flight frame; results and statistics survive it
    assign frame_clr = ~rst_n | SS_n;

    always_ff @(posedge SCLK or posedge frame_clr) begin
        if (frame_clr) begin
            bit_cnt <= '0;
            state   <= IDLE;
            mosi_sr <= '0;
            miso_sr <= '0;
        end else begin
            bit_cnt <= bit_cnt_nxt;
            state   <= state_nxt;
            mosi_sr <= {mosi_sr[FRAME_BITS-3:0], MOSI};
            miso_sr <= {miso_sr[FRAME_BITS-3:0], MISO};
        end
    end

    always_comb begin
        bit_cnt_nxt = bit_cnt + 4'd1;
        state_nxt   = state;
        complete    = 1'b0;
        case (state)
            IDLE: state_nxt = CMD;
            CMD: begin
                if (bit_cnt == 4'd8) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                    complete    = 1'b1;
                    state_nxt   = IDLE;
                    bit_cnt_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The 16th bit is still on the wires at the completing edge, so it is appended live
    assign mosi_word  = {mosi_sr, MOSI};
    assign miso_word  = {miso_sr, MISO};
    assign frame_done = complete & ~SS_n;
    assign wr_inc     = frame_done & ~mosi_word[RW_BIT];
    assign rd_inc     = frame_done & mosi_word[RW_BIT];
    assign abort_inc  = ~SS_n & (state == IDLE) & partial;

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            frm_rd    <= 1'b0;
            frm_addr  <= '0;
            frm_wdata <= '0;
            frm_rdata <= '0;
            frm_seq   <= '0;
            partial   <= 1'b0;
        end else if (!SS_n) begin
            partial <= ~complete;
            if (complete) begin
                frm_rd    <= mosi_word[RW_BIT];
                frm_addr  <= mosi_word[RW_BIT-1 -: ADDR_W];
                frm_wdata <= mosi_word[7:0];
                frm_rdata <= miso_word[7:0];
                frm_seq   <= frm_seq + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_inc) begin
            shadow[mosi_word[RW_BIT-1 -: ADDR_W]] <= mosi_word[7:0];
        end
    end

    assign shd_data   = shadow[shd_addr];
    assign setup_done = (shadow[SETUP_ADDR0] == SETUP_VAL0) &&
                        (shadow[SETUP_ADDR1] == SETUP_VAL1);

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .SCLK  (SCLK),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (wr_inc),
        .cnt   (wr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .SCLK  (SCLK),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (rd_inc),
        .cnt   (rd_cnt)
    );

    sat_counter #(.W(CNT_W)) u_abort_cnt (
        .SCLK  (SCLK),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (abort_inc),
        .cnt   (abort_cnt)
    );

endmodule

// File: tb/tb_spi_frame_monitor.sv
// tb/tb_spi_frame_monitor.sv - self-checking bench for spi_frame_monitor
module tb_spi_frame_monitor;
    import spi_mon_pkg::*;

    logic       SCLK;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic       frm_rd;
    logic [6:0] frm_addr;
    logic [7:0] frm_wdata;
    logic [7:0] frm_rdata;
    logic [7:0] frm_seq;
    logic [7:0] wr_cnt;
    logic [7:0] rd_cnt;
    logic [7:0] abort_cnt;
    logic       setup_done;
    logic [6:0] shd_addr;
    logic [7:0] shd_data;

    spi_frame_monitor dut (
        .SCLK       (SCLK),
        .rst_n      (rst_n),
        .SS_n       (SS_n),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .frm_rd     (frm_rd),
        .frm_addr   (frm_addr),
        .frm_wdata  (frm_wdata),
        .frm_rdata  (frm_rdata),
        .frm_seq    (frm_seq),
        .wr_cnt     (wr_cnt),
        .rd_cnt     (rd_cnt),
        .abort_cnt  (abort_cnt),
        .setup_done (setup_done),
        .shd_addr   (shd_addr),
        .shd_data   (shd_data)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic       m_rd;
    logic [6:0] m_addr;
    logic [7:0] m_wd;
    logic [7:0] m_rdat;
    int         m_seq;
    int         m_wr;
    int         m_rdc;
    int         m_ab;
    bit         m_partial;
    logic [7:0] m_shadow [128];

    typedef struct {
        int          n;
        logic [15:0] mo;
        logic [15:0] mi;
        logic [6:0]  sa;
        logic        e_rd;
        logic [6:0]  e_addr;
        logic [7:0]  e_wd;
        logic [7:0]  e_rdat;
        logic [7:0]  e_seq;
        logic [7:0]  e_wr;
        logic [7:0]  e_rdc;
        logic [7:0]  e_ab;
        logic [7:0]  e_shd;
        logic        e_setup;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat8(input int x);
        return (x >= 255) ? 255 : x + 1;
    endfunction

    task automatic model_reset();
        m_rd = 0; m_addr = 0; m_wd = 0; m_rdat = 0;
        m_seq = 0; m_wr = 0; m_rdc = 0; m_ab = 0; m_partial = 0;
        for (int i = 0; i < 128; i++) m_shadow[i] = 8'h00;
    endtask

    // A frame of n bits (1..16) inside one SS_n low window
    task automatic model_frame(input int n, input logic [15:0] mo, input logic [15:0] mi);
        if (m_partial) m_ab = sat8(m_ab);
        if (n == 16) begin
            m_rd   = mo[15];
            m_addr = mo[14:8];
            m_wd   = mo[7:0];
            m_rdat = mi[7:0];
            m_seq  = (m_seq + 1) % 256;
            if (mo[15]) m_rdc = sat8(m_rdc);
            else begin
                m_wr = sat8(m_wr);
                m_shadow[mo[14:8]] = mo[7:0];
            end
            m_partial = 0;
        end else begin
            m_partial = 1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        SS_n  = 1'b1;
        @(negedge SCLK);
        @(negedge SCLK);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a falling edge; returns at the next falling edge after one sample
    task automatic shift_bit(input logic m, input logic s);
        SS_n = 1'b0;
        MOSI = m;
        MISO = s;
        @(negedge SCLK);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        MISO = 1'b0;
        @(negedge SCLK);
    endtask

    task automatic send_frame(input int n, input logic [15:0] mo, input logic [15:0] mi);
        for (int i = 0; i < n; i++) shift_bit(mo[15-i], mi[15-i]);
        end_frame();
        model_frame(n, mo, mi);
    endtask

    task automatic check_model(input logic [6:0] sa);
        shd_addr = sa;
        #1;
        chk("m_frm_rd", frm_rd, m_rd);
        chk("m_frm_addr", frm_addr, m_addr);
        chk("m_frm_wdata", frm_wdata, m_wd);
        chk("m_frm_rdata", frm_rdata, m_rdat);
        chk("m_frm_seq", frm_seq, m_seq);
        chk("m_wr_cnt", wr_cnt, m_wr);
        chk("m_rd_cnt", rd_cnt, m_rdc);
        chk("m_abort_cnt", abort_cnt, m_ab);
        chk("m_shd_data", shd_data, m_shadow[sa]);
        chk("m_setup_done", setup_done,
            (m_shadow[DEF_SETUP_ADDR0] == DEF_SETUP_VAL0) &&
            (m_shadow[DEF_SETUP_ADDR1] == DEF_SETUP_VAL1));
    endtask

    initial begin
        SS_n = 1'b1; MOSI = 1'b0; MISO = 1'b0; rst_n = 1'b0; shd_addr = 7'h00;

        vecs[0] = '{16, 16'h0D02, 16'h0000, 7'h0D, 1'b0, 7'h0D, 8'h02, 8'h00, 8'd1, 8'd1, 8'd0, 8'd0, 8'h02, 1'b0};
        vecs[1] = '{16, 16'h1150, 16'h0000, 7'h0D, 1'b0, 7'h11, 8'h50, 8'h00, 8'd2, 8'd2, 8'd0, 8'd0, 8'h02, 1'b1};
        vecs[2] = '{16, 16'hA200, 16'h005A, 7'h22, 1'b1, 7'h22, 8'h00, 8'h5A, 8'd3, 8'd2, 8'd1, 8'd0, 8'h00, 1'b1};
        vecs[3] = '{ 9, 16'h0D33, 16'h00FF, 7'h0D, 1'b1, 7'h22, 8'h00, 8'h5A, 8'd3, 8'd2, 8'd1, 8'd0, 8'h02, 1'b1};
        vecs[4] = '{16, 16'h0D07, 16'h0000, 7'h0D, 1'b0, 7'h0D, 8'h07, 8'h00, 8'd4, 8'd3, 8'd1, 8'd1, 8'h07, 1'b0};
        vecs[5] = '{16, 16'h0D02, 16'h0000, 7'h0D, 1'b0, 7'h0D, 8'h02, 8'h00, 8'd5, 8'd4, 8'd1, 8'd1, 8'h02, 1'b1};
        vecs[6] = '{16, 16'h1151, 16'h0000, 7'h11, 1'b0, 7'h11, 8'h51, 8'h00, 8'd6, 8'd5, 8'd1, 8'd1, 8'h51, 1'b0};

        // Reset state
        do_reset();
        shd_addr = DEF_SETUP_ADDR0;
        #1;
        chk("rst_frm_seq", frm_seq, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_abort_cnt", abort_cnt, 0);
        chk("rst_frm_addr", frm_addr, 0);
        chk("rst_shd_data", shd_data, 0);
        chk("rst_setup_done", setup_done, 0);

        // Directed frame table
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].n, vecs[v].mo, vecs[v].mi);
            shd_addr = vecs[v].sa;
            #1;
            chk($sformatf("t%0d_frm_rd", v), frm_rd, vecs[v].e_rd);
            chk($sformatf("t%0d_frm_addr", v), frm_addr, vecs[v].e_addr);
            chk($sformatf("t%0d_frm_wdata", v), frm_wdata, vecs[v].e_wd);
            chk($sformatf("t%0d_frm_rdata", v), frm_rdata, vecs[v].e_rdat);
            chk($sformatf("t%0d_frm_seq", v), frm_seq, vecs[v].e_seq);
            chk($sformatf("t%0d_wr_cnt", v), wr_cnt, vecs[v].e_wr);
            chk($sformatf("t%0d_rd_cnt", v), rd_cnt, vecs[v].e_rdc);
            chk($sformatf("t%0d_abort_cnt", v), abort_cnt, vecs[v].e_ab);
            chk($sformatf("t%0d_shd_data", v), shd_data, vecs[v].e_shd);
            chk($sformatf("t%0d_setup_done", v), setup_done, vecs[v].e_setup);
        end

        // setup_done rises exactly on the 16th edge of the second setup write
        do_reset();
        send_frame(16, 16'h0D02, 16'h0000);
        begin
            logic [15:0] w;
            w = 16'h1150;
            for (int i = 0; i < 15; i++) shift_bit(w[15-i], 1'b0);
            #1;
            chk("setup_before_16th", setup_done, 0);
            chk("seq_before_16th", frm_seq, 1);
            shift_bit(w[0], 1'b0);
            #1;
            chk("setup_at_16th", setup_done, 1);
            chk("seq_at_16th", frm_seq, 2);
            end_frame();
        end

        // Saturation of wr_cnt and wrap of frm_seq
        do_reset();
        for (int i = 0; i < 260; i++) send_frame(16, {1'b0, 7'h20, 8'(i)}, 16'h0000);
        shd_addr = 7'h20;
        #1;
        chk("sat_wr_cnt", wr_cnt, 8'hFF);
        chk("wrap_frm_seq", frm_seq, 8'h04);
        chk("sat_rd_cnt", rd_cnt, 0);
        chk("sat_shd_data", shd_data, 8'h03);

        // Reset asserted mid-frame
        do_reset();
        send_frame(16, 16'h0D02, 16'h0000);
        for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        shd_addr = 7'h0D;
        #1;
        chk("mid_rst_frm_seq", frm_seq, 0);
        chk("mid_rst_wr_cnt", wr_cnt, 0);
        chk("mid_rst_frm_addr", frm_addr, 0);
        chk("mid_rst_shd_data", shd_data, 0);
        @(negedge SCLK);
        rst_n = 1'b1;
        end_frame();
        model_reset();
        send_frame(16, 16'h8D00, 16'h00C3);
        #1;
        chk("post_rst_frm_rd", frm_rd, 1);
        chk("post_rst_frm_addr", frm_addr, 7'h0D);
        chk("post_rst_frm_rdata", frm_rdata, 8'hC3);
        chk("post_rst_abort_cnt", abort_cnt, 0);
        chk("post_rst_frm_seq", frm_seq, 1);

        // Randomized frames against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            int          n;
            logic [6:0]  a;
            logic [7:0]  d;
            logic [15:0] mo;
            logic [15:0] mi;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            case ($urandom_range(0, 2))
                0: begin a = DEF_SETUP_ADDR0; d = ($urandom_range(0, 1) == 1) ? DEF_SETUP_VAL0 : 8'($urandom); end
                1: begin a = DEF_SETUP_ADDR1; d = ($urandom_range(0, 1) == 1) ? DEF_SETUP_VAL1 : 8'($urandom); end
                default: begin a = 7'($urandom); d = 8'($urandom); end
            endcase
            mo = {1'($urandom), a, d};
            mi = 16'($urandom);
            send_frame(n, mo, mi);
            check_model(($urandom_range(0, 1) == 1) ? a : 7'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
